// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, round index, FSM encoding
// and the byte substitution / round-constant helpers used by the round unit.
package aes_pkg;

  localparam int KW     = 128;
  localparam int NR     = 10;
  localparam int NUM_RK = NR + 1;

  typedef logic [3:0] rnd_t;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_EXPAND = 2'd1;
  localparam state_t ST_READY  = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input rnd_t r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/Key_Expansion_round.sv
// One AES-128 key-expansion round: derives round key r from round key r-1.
// Word 0 of the key sits in bits [127:96].
module Key_Expansion_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   round_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, tmp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign tmp = sub ^ {rcon(round_i), 24'h000000};

  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key schedule: one shared round unit iterated ten times,
// an 11-entry round-key store, and a registered read port for the cipher.
module key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  input  logic          flush,
  output logic          busy,
  output logic          key_ready,
  output logic          done,
  input  logic          rd_en,
  input  logic [3:0]    rd_idx,
  output logic [KW-1:0] rd_key,
  output logic          rd_valid
);
  // state  | meaning
  // IDLE   | no valid keys, waiting for start
  // EXPAND | writing round keys 1..10, one per cycle
  // READY  | all 11 round keys readable

  localparam rnd_t LAST_RND = rnd_t'(NR);

  state_t        state_q, state_d;
  rnd_t          rnd_q, rnd_d;
  logic [KW-1:0] work_q, work_d;
  logic          key_ready_q, key_ready_d;
  logic          done_q, done_d;
  logic          rd_valid_q;
  logic [KW-1:0] rd_key_q;
  logic [KW-1:0] store_q [NUM_RK];
  logic          store_we;
  rnd_t          store_idx;
  logic [KW-1:0] store_wdata;
  logic [KW-1:0] round_out;
  logic          rd_hit;
  logic [KW-1:0] rd_data;

  Key_Expansion_round u_round (
    .key_i   (work_q),
    .round_i (rnd_q),
    .key_o   (round_out)
  );

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    work_d      = work_q;
    key_ready_d = key_ready_q;
    done_d      = 1'b0;
    store_we    = 1'b0;
    store_idx   = '0;
    store_wdata = round_out;
    case (state_q)
      ST_EXPAND: begin
        store_we    = 1'b1;
        store_idx   = rnd_q;
        store_wdata = round_out;
        work_d      = round_out;
        if (rnd_q == LAST_RND) begin
          state_d     = ST_READY;
          rnd_d       = '0;
          key_ready_d = 1'b1;
          done_d      = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        // start takes priority over flush when both arrive together
        if (start) begin
          state_d     = ST_EXPAND;
          rnd_d       = 4'd1;
          work_d      = key_in;
          store_we    = 1'b1;
          store_idx   = '0;
          store_wdata = key_in;
          key_ready_d = 1'b0;
        end else if (flush) begin
          state_d     = ST_IDLE;
          key_ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      work_q      <= '0;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      work_q      <= work_d;
      key_ready_q <= key_ready_d;
      done_q      <= done_d;
    end
  end

  // Store is not reset; key_ready gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RK; i++) begin
      if (store_we && store_idx == rnd_t'(i)) begin
        store_q[i] <= store_wdata;
      end
    end
  end

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rd_idx == rnd_t'(i)) begin
        rd_hit  = 1'b1;
        rd_data = store_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else if (rd_en) begin
      rd_valid_q <= key_ready_q && rd_hit;
      rd_key_q   <= (key_ready_q && rd_hit) ? rd_data : '0;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign busy      = (state_q == ST_EXPAND);
  assign key_ready = key_ready_q;
  assign done      = done_q;
  assign rd_key    = rd_key_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: FIPS-197 vectors, corner sequences
// and random stimulus against a transaction-level key-schedule model.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         flush = 1'b0;
  logic         busy, key_ready, done;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
  logic         rd_valid;

  key_schedule_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .flush     (flush),
    .busy      (busy),
    .key_ready (key_ready),
    .done      (done),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key),
    .rd_valid  (rd_valid)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] OTHER_KEY = 128'h00112233445566778899aabbccddeeff;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: whole schedule computed from the FIPS-197 word recurrence
  logic [7:0]   m_sbox [256];
  logic [7:0]   m_rcon [11];
  logic [127:0] m_keys [11];
  logic [127:0] m_pend [11];
  int           m_cnt = 0;
  logic         m_ready = 1'b0, m_done = 1'b0, m_rdv = 1'b0;
  logic [127:0] m_rdk = '0;

  typedef struct {
    logic [3:0]   idx;
    logic         exp_valid;
    logic [127:0] exp_key;
  } rd_vec_t;

  rd_vec_t fips_tab [5];
  rd_vec_t zero_tab [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, r;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (b != 0 && gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      m_sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    m_rcon[0] = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      m_rcon[k] = r;
      r = xtime(r);
    end
  endtask

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t = t ^ {m_rcon[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_cnt = 0; m_ready = 1'b0; m_done = 1'b0; m_rdv = 1'b0; m_rdk = '0;
    end else begin
      if (rd_en) begin
        if (m_ready && rd_idx <= 4'd10) begin
          m_rdv = 1'b1; m_rdk = m_keys[int'(rd_idx)];
        end else begin
          m_rdv = 1'b0; m_rdk = '0;
        end
      end else begin
        m_rdv = 1'b0;
      end
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ready = 1'b1; m_done = 1'b1; m_keys = m_pend;
        end
      end else if (start) begin
        expand_model(key_in);
        m_cnt = 10; m_ready = 1'b0;
      end else if (flush) begin
        m_ready = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("m_busy", 128'(busy), 128'(m_cnt != 0));
    chk("m_key_ready", 128'(key_ready), 128'(m_ready));
    chk("m_done", 128'(done), 128'(m_done));
    chk("m_rd_valid", 128'(rd_valid), 128'(m_rdv));
    chk("m_rd_key", rd_key, m_rdk);
  endtask

  task automatic run_table(input rd_vec_t v, input string nm);
    rd_en = 1'b1;
    rd_idx = v.idx;
    tick();
    chk({nm, "_valid"}, 128'(rd_valid), 128'(v.exp_valid));
    chk({nm, "_key"}, rd_key, v.exp_key);
  endtask

  // Accept start on the next edge, then count cycles until done.
  task automatic expand_key(input logic [127:0] k, output int lat, output int n_done);
    start = 1'b1;
    key_in = k;
    tick();
    start = 1'b0;
    lat = 0;
    n_done = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done) begin
        n_done++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  initial begin
    int lat, nd, first_v;
    fips_tab[0] = '{4'd11, 1'b0, '0};
    fips_tab[1] = '{4'd15, 1'b0, '0};
    fips_tab[2] = '{4'd0, 1'b1, FIPS_KEY};
    fips_tab[3] = '{4'd1, 1'b1, FIPS_RK1};
    fips_tab[4] = '{4'd10, 1'b1, FIPS_RK10};
    zero_tab[0] = '{4'd10, 1'b1, ZERO_RK10};
    zero_tab[1] = '{4'd11, 1'b0, '0};
    zero_tab[2] = '{4'd15, 1'b0, '0};
    build_tables();

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", 128'(busy), 0);
    chk("rst_key_ready", 128'(key_ready), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_rd_valid", 128'(rd_valid), 0);
    chk("rst_rd_key", rd_key, 0);
    rst_n = 1'b1;
    tick();

    // FIPS expansion with reads hammering index 0 throughout
    rd_en = 1'b1; rd_idx = 4'd0;
    start = 1'b1; key_in = FIPS_KEY;
    tick();
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 1);
    lat = 0; first_v = 0; nd = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done) begin nd++; if (lat == 0) lat = i; end
      if (rd_valid && first_v == 0) first_v = i;
      if (i <= 10) begin
        chk("busy_rd_valid", 128'(rd_valid), 0);
        chk("busy_rd_key", rd_key, 0);
      end
    end
    chk("done_latency", 128'(lat), 10);
    chk("done_count", 128'(nd), 1);
    chk("first_rd_valid", 128'(first_v), 11);
    foreach (fips_tab[i]) run_table(fips_tab[i], "fips_rd");
    rd_en = 1'b0;
    tick();
    chk("hold_rd_valid", 128'(rd_valid), 0);
    chk("hold_rd_key", rd_key, FIPS_RK10);

    // start again at EXPAND cycle 5 is ignored
    start = 1'b1; key_in = FIPS_KEY;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; key_in = OTHER_KEY;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done) nd++; end
    chk("ignored_start_done_count", 128'(nd), 1);
    foreach (fips_tab[i]) run_table(fips_tab[i], "ignore_rd");

    // re-key from READY with an all-zero key
    rd_en = 1'b0;
    start = 1'b1; key_in = '0;
    tick();
    start = 1'b0;
    chk("rekey_key_ready_drop", 128'(key_ready), 0);
    chk("rekey_busy", 128'(busy), 1);
    lat = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done && lat == 0) lat = i;
    end
    chk("rekey_latency", 128'(lat), 10);
    foreach (zero_tab[i]) run_table(zero_tab[i], "zero_rd");

    // reset at EXPAND cycle 4 aborts cleanly
    rd_en = 1'b0;
    start = 1'b1; key_in = OTHER_KEY;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 128'(busy), 0);
    chk("abort_key_ready", 128'(key_ready), 0);
    chk("abort_done", 128'(done), 0);
    chk("abort_rd_valid", 128'(rd_valid), 0);
    chk("abort_rd_key", rd_key, 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (done) nd++; end
    chk("abort_no_done", 128'(nd), 0);
    expand_key(FIPS_KEY, lat, nd);
    chk("after_abort_latency", 128'(lat), 10);
    foreach (fips_tab[i]) run_table(fips_tab[i], "after_abort_rd");

    // flush in READY, then start+flush together
    rd_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_key_ready", 128'(key_ready), 0);
    rd_en = 1'b1; rd_idx = 4'd1;
    tick();
    chk("flush_rd_valid", 128'(rd_valid), 0);
    chk("flush_rd_key", rd_key, 0);
    rd_en = 1'b0;
    expand_key(FIPS_KEY, lat, nd);
    start = 1'b1; flush = 1'b1; key_in = '0;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", 128'(busy), 1);
    chk("start_flush_key_ready", 128'(key_ready), 0);
    for (int i = 0; i < 12; i++) tick();
    run_table(zero_tab[0], "start_flush_rd");

    // random stimulus, every cycle compared against the model
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 79) != 0);
      start  = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      rd_en  = $urandom_range(0, 1) == 1;
      rd_idx = 4'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; rd_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequential AES-128 key-schedule controller. Accepts a cipher key and drives a single shared instance of the existing Key_Expansion_round unit once per cycle for 10 cycles. Stores round keys 0..10 in an internal key store and serves them to the cipher datapath through a registered read port. It replaces the 10-deep combinational chain with one round unit plus storage.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) supported
KW, 128, key/round-key width in bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request expansion of key_in; accepted only when busy=0
key_in  in  KW  cipher key, same state-matrix byte layout as Key_Expansion_round input
flush  in  1  invalidate stored keys (key_ready->0); ignored while busy
busy  out  1  expansion in progress
key_ready  out  1  all 11 round keys valid
done  out  1  one-cycle pulse when round key 10 is written
rd_en  in  1  read request
rd_idx  in  4  round key index 0..10
rd_key  out  KW  round key read data
rd_valid  out  1  rd_key valid this cycle

Behaviour:
- One clock, clk; reset is synchronous and active-low, rst_n.
- On reset: state=IDLE; busy=0, key_ready=0, done=0, rd_valid=0, rd_key=0, round counter=0. Key store contents are don't-care but unreadable, because key_ready=0.
- FSM states: IDLE, EXPAND, READY.
- IDLE/READY with start=1 at edge E0:
  - store[0] <= key_in; working reg <= key_in; rnd <= 1; state <= EXPAND.
  - key_ready <= 0; busy=1 from E0.
- EXPAND, each edge Ek (k=1..10):
  - next = Key_Expansion_round(working, rnd[3:0]).
  - store[rnd] <= next; working <= next; rnd <= rnd+1.
- At E10 (rnd=10): state <= READY; done=1 for the cycle after E10 only; busy <= 0; key_ready <= 1.
- Latency: start sampled at E0 -> done/key_ready high after E10. Exactly 10 cycles busy, zero idle bubbles.
- start while busy: ignored, no queuing. start in READY: re-key; key_ready drops after the accepting edge.
- flush in READY: state <= IDLE, key_ready <= 0. start and flush in the same cycle: start wins.
- Read port:
  - rd_en=1 at edge sets rd_valid=1 next cycle, and rd_key = store[rd_idx], registered with 1-cycle latency.
  - Conditions for a valid read: key_ready=1 and rd_idx<=10.
  - If key_ready=0 or rd_idx>10: rd_valid=0, rd_key=0.
  - rd_en=0: rd_valid=0, rd_key holds its previous value.
- Read of index k during EXPAND is rejected (key_ready=0). Reads are never partially valid.
- rst_n low mid-EXPAND: aborts next edge to the reset state; a fresh start is required.
- Round index fed to the round unit is 4-bit, values 1..10 only. rnd never wraps, and is cleared to 0 on leaving EXPAND.

Decomposition:
- Shared package aes_pkg: KW, NR, NUM_RK=NR+1, round index typedef (4-bit), FSM state enum {IDLE, EXPAND, READY}.
- Sub-module: exactly one instance of existing Key_Expansion_round as the round datapath. The key store (11 x KW register array) and the FSM live inline in key_schedule_ctrl.

Test Plan:
- FIPS-197 key, words 2b7e1516 28aed2a6 abf71588 09cf4f3c; pulse start:
  - done exactly 10 cycles after the accepting edge.
  - rd_idx=1 -> a0fafe17 88542cb1 23a33939 2a6c7605.
  - rd_idx=10 -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - rd_idx=0 -> original key.
- Reads during expansion: rd_en every cycle with rd_idx=0 while busy -> rd_valid=0, rd_key=0. First rd_valid=1 appears only in the cycle after key_ready rises.
- start re-asserted at cycle 5 of EXPAND with a different key -> ignored. Final keys match the first key; done pulses once.
- Re-key from READY with all-zero key -> key_ready falls, 10 cycles later rd_idx=10 returns b4ef5bcb 3e92e211 23e951cf 6f8f188e. rd_idx=11 and rd_idx=15 -> rd_valid=0.
- rst_n=0 for one cycle at EXPAND cycle 4 -> all outputs at reset values next cycle; no done pulse. Subsequent start produces correct FIPS-197 keys.
- flush in READY -> key_ready=0 and reads rejected. start+flush in the same cycle -> expansion starts, busy=1.
